// File: rtl/enc_pkg.sv
// Shared constants and helpers for the key/cell event encoder.
package enc_pkg;
    localparam int MODE_STRICT   = 0;
    localparam int MODE_PRIORITY = 1;

    // Width of an index into an n-wide vector; never below one bit.
    function automatic int code_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational index encoder: lowest set index, any-bit flag and a
// multi-bit flag that is only raised when multi-bit input is an error.
module onehot_prio_enc
    import enc_pkg::*;
#(
    parameter  int N_IN      = 16,
    parameter  int PRIO_MODE = MODE_STRICT,
    localparam int W_OUT     = code_w(N_IN)
) (
    input  logic [N_IN-1:0]  vec,
    output logic [W_OUT-1:0] code,
    output logic             any,
    output logic             multi
);
    always_comb begin
        code  = '0;
        any   = |vec;
        // Scan downward so the lowest set index is written last and wins.
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec[i]) code = W_OUT'(i);
        end
        multi = (PRIO_MODE == MODE_STRICT) && ((vec & (vec - N_IN'(1))) != '0);
    end
endmodule

// File: rtl/key_event_encoder.sv
// Rising-edge key event encoder with a one-entry valid/ready holding
// register, strict/priority multi-press handling and sticky overflow.
module key_event_encoder
    import enc_pkg::*;
#(
    parameter  int N_IN      = 16,
    parameter  int PRIO_MODE = MODE_STRICT,
    localparam int W_OUT     = code_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in,
    output logic [W_OUT-1:0] out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic             ovf,
    input  logic             ovf_clr
);
    logic [N_IN-1:0]  in_prev;
    logic [N_IN-1:0]  rise;
    logic [W_OUT-1:0] cand_code;
    logic             rise_any;
    logic             rise_multi;
    logic             cand;
    logic             xfer;
    logic             load;
    logic             drop;

    assign rise = in & ~in_prev;

    onehot_prio_enc #(
        .N_IN      (N_IN),
        .PRIO_MODE (PRIO_MODE)
    ) u_enc (
        .vec   (rise),
        .code  (cand_code),
        .any   (rise_any),
        .multi (rise_multi)
    );

    assign cand = rise_any & ~rise_multi;
    assign xfer = out_valid & out_ready;
    // A transfer in the same cycle frees the slot, so back-to-back loads need no bubble.
    assign load = cand & (~out_valid | out_ready);
    assign drop = cand & out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_prev   <= '1;
            out_code  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            in_prev <= in;
            err     <= rise_multi;
            if (load) begin
                out_valid <= 1'b1;
                out_code  <= cand_code;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            // Set wins over a coincident clear.
            ovf <= drop | (ovf & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_key_event_encoder.sv
// Bench: strict and priority instances share stimulus; directed table plus
// randomized run against a behavioural model.
module tb_key_event_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic        out_ready;
    logic        ovf_clr;
    logic [3:0]  code_s, code_p;
    logic        valid_s, valid_p, err_s, err_p, ovf_s, ovf_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_encoder #(.N_IN(16), .PRIO_MODE(0)) dut_s (
        .clk(clk), .rst(rst), .in(in), .out_code(code_s), .out_valid(valid_s),
        .out_ready(out_ready), .err(err_s), .ovf(ovf_s), .ovf_clr(ovf_clr));

    key_event_encoder #(.N_IN(16), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst), .in(in), .out_code(code_p), .out_valid(valid_p),
        .out_ready(out_ready), .err(err_p), .ovf(ovf_p), .ovf_clr(ovf_clr));

    // Behavioural model, index 0 = strict, 1 = priority.
    logic [15:0] m_prev [2];
    bit          m_valid[2];
    logic [3:0]  m_code [2];
    bit          m_err  [2];
    bit          m_ovf  [2];
    bit          m_code_known[2];

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_prev[m] = 16'hffff; m_valid[m] = 0; m_code[m] = 0;
                m_err[m] = 0; m_ovf[m] = 0; m_code_known[m] = 1;
            end else begin
                logic [15:0] r;
                int          n, low;
                bit          has, dropped;
                r = in & ~m_prev[m];
                n = $countones(r);
                low = 0;
                for (int b = 15; b >= 0; b--) if (r[b]) low = b;
                has = (m == 1) ? (n > 0) : (n == 1);
                m_err[m] = (m == 0) && (n > 1);
                dropped = 0;
                if (has && (!m_valid[m] || out_ready)) begin
                    m_valid[m] = 1; m_code[m] = low[3:0]; m_code_known[m] = 1;
                end else if (has) begin
                    dropped = 1;
                end else if (m_valid[m] && out_ready) begin
                    m_valid[m] = 0; m_code_known[m] = 0;
                end
                m_ovf[m] = dropped || (m_ovf[m] && !ovf_clr);
                m_prev[m] = in;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("s_valid", 32'(valid_s), 32'(m_valid[0]));
        chk("s_err",   32'(err_s),   32'(m_err[0]));
        chk("s_ovf",   32'(ovf_s),   32'(m_ovf[0]));
        if (m_valid[0] || m_code_known[0]) chk("s_code", 32'(code_s), 32'(m_code[0]));
        chk("p_valid", 32'(valid_p), 32'(m_valid[1]));
        chk("p_err",   32'(err_p),   32'(m_err[1]));
        chk("p_ovf",   32'(ovf_p),   32'(m_ovf[1]));
        if (m_valid[1] || m_code_known[1]) chk("p_code", 32'(code_p), 32'(m_code[1]));
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic cycle(input bit r, input logic [15:0] v, input bit rdy, input bit clr);
        rst = r; in = v; out_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        #1;
        model_step();
        chk_model();
    endtask

    typedef struct {
        bit          rst;
        logic [15:0] in;
        bit          rdy;
        bit          clr;
        bit          v;
        logic [3:0]  c;
        bit          e;
        bit          o;
    } vec_t;

    function automatic vec_t mk(bit r, logic [15:0] i, bit rdy, bit clr,
                                bit v, logic [3:0] c, bit e, bit o);
        vec_t t;
        t.rst = r; t.in = i; t.rdy = rdy; t.clr = clr;
        t.v = v; t.c = c; t.e = e; t.o = o;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1; in = '0; out_ready = 0; ovf_clr = 0;

        // Directed expectations for the strict instance.
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0,  0, 0, 0)); // reset state
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 16'h0010, 1, 0, 1,  4, 0, 0)); // single press
        tbl.push_back(mk(0, 16'h0010, 1, 0, 0,  0, 0, 0)); // consumed, held key
        tbl.push_back(mk(0, 16'h0010, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, 16'h8000, 1, 0, 0,  0, 0, 0)); // held through reset
        tbl.push_back(mk(0, 16'h8000, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 16'h8000, 1, 0, 1, 15, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 16'h0009, 1, 0, 0,  0, 1, 0)); // multi rise -> err
        tbl.push_back(mk(0, 16'h0009, 1, 0, 0,  0, 0, 0)); // err one cycle only
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 16'h0008, 0, 0, 1,  3, 0, 0)); // code 3 pending
        tbl.push_back(mk(0, 16'h0088, 0, 0, 1,  3, 0, 1)); // bit 7 dropped
        tbl.push_back(mk(0, 16'h0088, 0, 1, 1,  3, 0, 0)); // clear
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1,  3, 0, 0));
        tbl.push_back(mk(0, 16'h0080, 0, 1, 1,  3, 0, 1)); // set wins over clear
        tbl.push_back(mk(0, 16'h0080, 0, 0, 1,  3, 0, 1));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 0, 1)); // drain
        tbl.push_back(mk(0, 16'h0004, 0, 1, 1,  2, 0, 0)); // code 2 pending
        tbl.push_back(mk(0, 16'h0204, 1, 0, 1,  9, 0, 0)); // back-to-back load
        tbl.push_back(mk(0, 16'h0204, 0, 0, 1,  9, 0, 0)); // held while stalled
        tbl.push_back(mk(0, 16'h0205, 0, 0, 1,  9, 0, 1)); // drop -> ovf
        tbl.push_back(mk(1, 16'h0205, 0, 0, 0,  0, 0, 0)); // reset mid-operation
        tbl.push_back(mk(0, 16'h0205, 1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0,  0, 0, 0));

        foreach (tbl[k]) begin
            cycle(tbl[k].rst, tbl[k].in, tbl[k].rdy, tbl[k].clr);
            chk($sformatf("tbl%0d_valid", k), 32'(valid_s), 32'(tbl[k].v));
            chk($sformatf("tbl%0d_err", k),   32'(err_s),   32'(tbl[k].e));
            chk($sformatf("tbl%0d_ovf", k),   32'(ovf_s),   32'(tbl[k].o));
            if (tbl[k].v || tbl[k].rst)
                chk($sformatf("tbl%0d_code", k), 32'(code_s), 32'(tbl[k].c));
        end

        // Priority mode: same multi-bit rise yields the lowest index, no err.
        cycle(1, 16'h0000, 1, 0);
        cycle(0, 16'h0000, 1, 0);
        cycle(0, 16'h0009, 1, 0);
        chk("prio_valid", 32'(valid_p), 32'd1);
        chk("prio_code",  32'(code_p),  32'd0);
        chk("prio_err",   32'(err_p),   32'd0);
        chk("strict_err", 32'(err_s),   32'd1);
        cycle(0, 16'h0009, 1, 0);
        chk("prio_err2",   32'(err_p),   32'd0);
        chk("prio_valid2", 32'(valid_p), 32'd0);

        // Randomized run: sparse keys so single presses dominate.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if ($urandom_range(3) != 0) v = v & 16'($urandom) & 16'($urandom);
            if ($urandom_range(4) == 0) v = in;
            cycle($urandom_range(99) == 0, v, $urandom_range(2) != 0,
                  $urandom_range(7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
